// File: rtl/irq_entry_seq_pkg.sv
// Shared CPU definitions for the IRQ entry sequencer: FSM state encoding,
// IRQ vector / mode constants, CPSR bit positions and the CPSR rewrite
// applied on IRQ entry. Optional macro: IRQ_HALT_WAKE_EN adds the HALT state.
package cpu_pkg;

  localparam logic [31:0] IRQ_VECTOR    = 32'h0000_0018;
  localparam logic [4:0]  CPSR_MODE_IRQ = 5'b10010;
  localparam int          CPSR_I        = 7;
  localparam int          CPSR_T        = 5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_BOUND = 3'd1,
    S_SAVE_LR    = 3'd2,
    S_SAVE_SPSR  = 3'd3,
    S_SWITCH     = 3'd4,
`ifdef IRQ_HALT_WAKE_EN
    S_VECTOR     = 3'd5,
    S_HALT       = 3'd6
`else
    S_VECTOR     = 3'd5
`endif
  } irq_state_e;

  // New CPSR on IRQ entry: IRQ mode, IRQs masked, ARM state, rest untouched.
  function automatic logic [31:0] irq_entry_cpsr(input logic [31:0] cur);
    logic [31:0] r;
    r         = cur;
    r[4:0]    = CPSR_MODE_IRQ;
    r[CPSR_I] = 1'b1;
    r[CPSR_T] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/irq_entry_seq_if.sv
// Bus between the CPU core and the IRQ entry sequencer. The slave modport is
// the sequencer side. Optional macro: IRQ_HALT_WAKE_EN adds halt_req,
// irq_wake and halted.
interface irq_entry_seq_if;

  logic        nIRQ;
  logic [31:0] cpsr;
  logic        instr_boundary;
  logic [31:0] next_pc;
  logic        rf_ack;
  logic        stall;
  logic        rf_wr_en;
  logic        rf_wr_sel;
  logic [31:0] rf_wr_data;
  logic        cpsr_wr_en;
  logic [31:0] cpsr_wr_data;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        busy;
`ifdef IRQ_HALT_WAKE_EN
  logic        halt_req;
  logic        irq_wake;
  logic        halted;

  modport master (
    output nIRQ, cpsr, instr_boundary, next_pc, rf_ack, halt_req, irq_wake,
    input  stall, rf_wr_en, rf_wr_sel, rf_wr_data, cpsr_wr_en, cpsr_wr_data,
           pc_load, pc_value, busy, halted
  );

  modport slave (
    input  nIRQ, cpsr, instr_boundary, next_pc, rf_ack, halt_req, irq_wake,
    output stall, rf_wr_en, rf_wr_sel, rf_wr_data, cpsr_wr_en, cpsr_wr_data,
           pc_load, pc_value, busy, halted
  );
`else
  modport master (
    output nIRQ, cpsr, instr_boundary, next_pc, rf_ack,
    input  stall, rf_wr_en, rf_wr_sel, rf_wr_data, cpsr_wr_en, cpsr_wr_data,
           pc_load, pc_value, busy
  );

  modport slave (
    input  nIRQ, cpsr, instr_boundary, next_pc, rf_ack,
    output stall, rf_wr_en, rf_wr_sel, rf_wr_data, cpsr_wr_en, cpsr_wr_data,
           pc_load, pc_value, busy
  );
`endif

endinterface

// File: rtl/irq_entry_seq.sv
// IRQ entry sequencer: waits for an instruction boundary, banks LR and SPSR
// through the register-file handshake, switches the CPSR into IRQ mode and
// branches to the IRQ vector. Optional macro: IRQ_HALT_WAKE_EN adds a HALT
// state left on irq_wake regardless of interrupt masking.
module irq_entry_seq
  import cpu_pkg::*;
(
  input logic           clock,
  input logic           reset,
  irq_entry_seq_if.slave bus
);

  irq_state_e  state_q, state_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] spsr_q, spsr_d;
  logic        withdraw;
  logic        capture;

  // A request counts only while nIRQ is low and the I bit is clear.
  assign withdraw = bus.nIRQ | bus.cpsr[CPSR_I];
  assign capture  = (state_q == S_WAIT_BOUND) && !withdraw && bus.instr_boundary;
  assign lr_d     = capture ? (bus.next_pc + 32'd4) : lr_q;
  assign spsr_d   = capture ? bus.cpsr : spsr_q;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Return address and saved CPSR, captured at the redirect boundary.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lr_q   <= '0;
      spsr_q <= '0;
    end else begin
      lr_q   <= lr_d;
      spsr_q <= spsr_d;
    end
  end

  // Next-state logic; withdrawal beats a same-cycle boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!withdraw) state_d = S_WAIT_BOUND;
`ifdef IRQ_HALT_WAKE_EN
        else if (bus.halt_req) state_d = S_HALT;
`endif
      end
      S_WAIT_BOUND: begin
        if (withdraw)                state_d = S_IDLE;
        else if (bus.instr_boundary) state_d = S_SAVE_LR;
      end
      S_SAVE_LR:   if (bus.rf_ack) state_d = S_SAVE_SPSR;
      S_SAVE_SPSR: if (bus.rf_ack) state_d = S_SWITCH;
      S_SWITCH:    state_d = S_VECTOR;
      S_VECTOR:    state_d = S_IDLE;
`ifdef IRQ_HALT_WAKE_EN
      S_HALT:      if (bus.irq_wake) state_d = S_IDLE;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; data buses are zero outside their state.
  always_comb begin
    bus.stall        = 1'b0;
    bus.busy         = (state_q != S_IDLE);
    bus.rf_wr_en     = 1'b0;
    bus.rf_wr_sel    = 1'b0;
    bus.rf_wr_data   = '0;
    bus.cpsr_wr_en   = 1'b0;
    bus.cpsr_wr_data = '0;
    bus.pc_load      = 1'b0;
    bus.pc_value     = '0;
`ifdef IRQ_HALT_WAKE_EN
    bus.halted       = 1'b0;
`endif
    unique case (state_q)
      S_SAVE_LR: begin
        bus.stall      = 1'b1;
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_data = lr_q;
      end
      S_SAVE_SPSR: begin
        bus.stall      = 1'b1;
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_sel  = 1'b1;
        bus.rf_wr_data = spsr_q;
      end
      S_SWITCH: begin
        bus.stall        = 1'b1;
        bus.cpsr_wr_en   = 1'b1;
        bus.cpsr_wr_data = irq_entry_cpsr(spsr_q);
      end
      S_VECTOR: begin
        bus.stall    = 1'b1;
        bus.pc_load  = 1'b1;
        bus.pc_value = IRQ_VECTOR;
      end
`ifdef IRQ_HALT_WAKE_EN
      S_HALT: begin
        bus.stall  = 1'b1;
        bus.halted = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_entry_seq.sv
// Self-checking bench for irq_entry_seq: a phase-level reference model
// checked every cycle, plus directed literal expectations per scenario.
// Optional macro: IRQ_HALT_WAKE_EN enables the halt/wake scenario.
module tb_irq_entry_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_entry_seq_if bus();

  irq_entry_seq dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase 0 idle, 1 armed, 2 LR write, 3 SPSR write,
  // 4 CPSR switch, 5 branch, 7 halted.
  int          m_phase = 0;
  logic [31:0] m_lr    = '0;
  logic [31:0] m_spsr  = '0;
  logic        req_ok;
  logic        halt_in, wake_in, dut_halted;

`ifdef IRQ_HALT_WAKE_EN
  assign halt_in    = bus.halt_req;
  assign wake_in    = bus.irq_wake;
  assign dut_halted = bus.halted;
`else
  assign halt_in    = 1'b0;
  assign wake_in    = 1'b0;
  assign dut_halted = 1'b0;
`endif

  assign req_ok = (bus.nIRQ == 1'b0) && (bus.cpsr[7] == 1'b0);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_lr    <= '0;
      m_spsr  <= '0;
    end else if (m_phase == 0) begin
      if (req_ok)       m_phase <= 1;
      else if (halt_in) m_phase <= 7;
    end else if (m_phase == 1) begin
      if (!req_ok) m_phase <= 0;
      else if (bus.instr_boundary) begin
        m_phase <= 2;
        m_lr    <= bus.next_pc + 32'd4;
        m_spsr  <= bus.cpsr;
      end
    end else if (m_phase == 2 || m_phase == 3) begin
      if (bus.rf_ack) m_phase <= m_phase + 1;
    end else if (m_phase == 4) begin
      m_phase <= 5;
    end else if (m_phase == 5) begin
      m_phase <= 0;
    end else if (m_phase == 7) begin
      if (wake_in) m_phase <= 0;
    end
  end

  function automatic logic [102:0] model_out();
    logic [31:0] wd, cd, pv;
    wd = (m_phase == 2) ? m_lr : (m_phase == 3) ? m_spsr : 32'h0;
    cd = (m_phase == 4) ? ((m_spsr & ~32'h0000_00BF) | 32'h0000_0092) : 32'h0;
    pv = (m_phase == 5) ? 32'h0000_0018 : 32'h0;
    return {m_phase != 0, m_phase >= 2, m_phase == 2 || m_phase == 3, m_phase == 3,
            wd, m_phase == 4, cd, m_phase == 5, pv, m_phase == 7};
  endfunction

  logic [102:0] dut_vec;
  assign dut_vec = {bus.busy, bus.stall, bus.rf_wr_en, bus.rf_wr_sel, bus.rf_wr_data,
                    bus.cpsr_wr_en, bus.cpsr_wr_data, bus.pc_load, bus.pc_value, dut_halted};

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if (dut_vec !== model_out()) begin
        n_errors++;
        $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, dut_vec, model_out());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.nIRQ = 1'b1; bus.cpsr = 32'h0; bus.instr_boundary = 1'b0;
    bus.next_pc = 32'h0; bus.rf_ack = 1'b1;
`ifdef IRQ_HALT_WAKE_EN
    bus.halt_req = 1'b0; bus.irq_wake = 1'b0;
`endif
    step(); step();
    cmp_en = 1'b1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_rf_wr_en", bus.rf_wr_en, 0);
    chk("reset_pc_value", bus.pc_value, 0);
    rst_n = 1'b1;

    // Case 1: ARM mode entry, rf_ack tied high; nIRQ drops away mid-sequence.
    bus.cpsr = 32'h0000_001F; bus.nIRQ = 1'b0; step();
    chk("c1_wait_busy", bus.busy, 1);
    chk("c1_wait_stall", bus.stall, 0);
    bus.instr_boundary = 1'b1; bus.next_pc = 32'h0800_0100; step();
    bus.instr_boundary = 1'b0; bus.nIRQ = 1'b1;
    chk("c1_lr_en", bus.rf_wr_en, 1);
    chk("c1_lr_sel", bus.rf_wr_sel, 0);
    chk("c1_lr_data", bus.rf_wr_data, 32'h0800_0104);
    step();
    chk("c1_spsr_sel", bus.rf_wr_sel, 1);
    chk("c1_spsr_data", bus.rf_wr_data, 32'h0000_001F);
    step();
    chk("c1_cpsr_en", bus.cpsr_wr_en, 1);
    chk("c1_cpsr_data", bus.cpsr_wr_data, 32'h0000_0092);
    step();
    chk("c1_pc_load", bus.pc_load, 1);
    chk("c1_pc_value", bus.pc_value, 32'h0000_0018);
    step();
    chk("c1_idle_busy", bus.busy, 0);
    chk("c1_idle_pc_load", bus.pc_load, 0);

    // Case 2: Thumb state is cleared in the new CPSR.
    bus.cpsr = 32'h0000_003F; bus.nIRQ = 1'b0; step();
    bus.instr_boundary = 1'b1; bus.next_pc = 32'h0000_2000; step();
    bus.instr_boundary = 1'b0; bus.nIRQ = 1'b1;
    chk("c2_lr_data", bus.rf_wr_data, 32'h0000_2004);
    step();
    chk("c2_spsr_data", bus.rf_wr_data, 32'h0000_003F);
    step();
    chk("c2_cpsr_data", bus.cpsr_wr_data, 32'h0000_0092);
    step(); step();
    chk("c2_idle_busy", bus.busy, 0);

    // Case 3: withdrawal beats a same-cycle boundary; I bit blocks entry.
    bus.cpsr = 32'h0000_001F; bus.nIRQ = 1'b0; step();
    chk("c3_armed", bus.busy, 1);
    bus.nIRQ = 1'b1; bus.instr_boundary = 1'b1; bus.next_pc = 32'h0000_4000; step();
    bus.instr_boundary = 1'b0;
    chk("c3_withdraw_busy", bus.busy, 0);
    chk("c3_withdraw_wr", bus.rf_wr_en, 0);
    bus.nIRQ = 1'b0; step();
    bus.cpsr = 32'h0000_009F; bus.instr_boundary = 1'b1; step();
    bus.instr_boundary = 1'b0;
    chk("c3_mask_withdraw", bus.busy, 0);
    step();
    chk("c3_masked_idle", bus.busy, 0);
    bus.nIRQ = 1'b1; bus.cpsr = 32'h0000_001F;

    // Case 4: rf_ack low for three cycles stretches the LR write to four.
    bus.nIRQ = 1'b0; step();
    bus.instr_boundary = 1'b1; bus.next_pc = 32'h0000_1000; bus.rf_ack = 1'b0; step();
    bus.instr_boundary = 1'b0; bus.nIRQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("c4_hold_en", bus.rf_wr_en, 1);
      chk("c4_hold_sel", bus.rf_wr_sel, 0);
      chk("c4_hold_data", bus.rf_wr_data, 32'h0000_1004);
      bus.rf_ack = (i == 3);
      step();
    end
    chk("c4_spsr_sel", bus.rf_wr_sel, 1);
    chk("c4_spsr_data", bus.rf_wr_data, 32'h0000_001F);
    step(); step(); step();
    chk("c4_idle_busy", bus.busy, 0);

    // Case 5: reset in the middle of the SPSR write leaves nothing behind.
    bus.nIRQ = 1'b0; step();
    bus.instr_boundary = 1'b1; bus.next_pc = 32'h0000_3000; step();
    bus.instr_boundary = 1'b0; bus.nIRQ = 1'b1; bus.rf_ack = 1'b1; step();
    bus.rf_ack = 1'b0;
    chk("c5_in_spsr", bus.rf_wr_sel, 1);
    rst_n = 1'b0; step();
    chk("c5_rst_busy", bus.busy, 0);
    chk("c5_rst_stall", bus.stall, 0);
    chk("c5_rst_wr_en", bus.rf_wr_en, 0);
    chk("c5_rst_wr_data", bus.rf_wr_data, 0);
    rst_n = 1'b1; bus.rf_ack = 1'b1; step();
    chk("c5_after_busy", bus.busy, 0);

    // Case 6: return address wraps at the top of the address space.
    bus.nIRQ = 1'b0; step();
    bus.instr_boundary = 1'b1; bus.next_pc = 32'hFFFF_FFFC; step();
    bus.instr_boundary = 1'b0; bus.nIRQ = 1'b1;
    chk("c6_lr_wrap", bus.rf_wr_data, 32'h0000_0000);
    chk("c6_lr_en", bus.rf_wr_en, 1);
    step(); step(); step(); step();
    chk("c6_idle_busy", bus.busy, 0);

`ifdef IRQ_HALT_WAKE_EN
    // Halt, then wake even though the I bit is set; a pending IRQ follows.
    bus.halt_req = 1'b1; step();
    bus.halt_req = 1'b0;
    chk("c6_halted", dut_halted, 1);
    chk("c6_halt_stall", bus.stall, 1);
    step();
    chk("c6_halt_hold", dut_halted, 1);
    bus.cpsr = 32'h0000_009F; bus.irq_wake = 1'b1; step();
    bus.irq_wake = 1'b0;
    chk("c6_woken", dut_halted, 0);
    chk("c6_woken_busy", bus.busy, 0);
    bus.cpsr = 32'h0000_001F; bus.nIRQ = 1'b0; step();
    chk("c6_pending_irq", bus.busy, 1);
    bus.nIRQ = 1'b1; step();
    chk("c6_pending_drop", bus.busy, 0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
